// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz race controller: state codes, display
// player codes and the key priority encoder.
package quiz_pkg;
  localparam int BCD_W = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_LOCKED  = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_FOUL    = 3'd4;

  localparam logic [3:0] PLAYER_NONE  = 4'd0;
  localparam logic [3:0] PLAYER_BLANK = 4'd10;

  // Lowest key index wins; returns the 1-based player number.
  function automatic logic [3:0] prio_player(input logic [3:0] keys);
    if (keys[0])      prio_player = 4'd1;
    else if (keys[1]) prio_player = 4'd2;
    else if (keys[2]) prio_player = 4'd3;
    else if (keys[3]) prio_player = 4'd4;
    else              prio_player = PLAYER_NONE;
  endfunction
endpackage

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD down counter with preset load; flags when the next
// decrement lands on 00.
module bcd_down_counter2
  import quiz_pkg::*;
#(
  parameter logic [BCD_W-1:0] INIT_H = 4'd3,
  parameter logic [BCD_W-1:0] INIT_L = 4'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [BCD_W-1:0] dig_h,
  output logic [BCD_W-1:0] dig_l,
  output logic             zero_next
);
  logic [BCD_W-1:0] h_q, h_d, l_q, l_d;

  always_comb begin
    h_d = h_q;
    l_d = l_q;
    if (load) begin
      h_d = INIT_H;
      l_d = INIT_L;
    end else if (dec) begin
      if (l_q == 4'd0) begin
        l_d = 4'd9;
        h_d = h_q - 4'd1;
      end else begin
        l_d = l_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= INIT_H;
      l_q <= INIT_L;
    end else begin
      h_q <= h_d;
      l_q <= l_d;
    end
  end

  assign dig_h     = h_q;
  assign dig_l     = l_q;
  assign zero_next = (h_q == 4'd0) && (l_q == 4'd1);
endmodule

// File: rtl/quiz_race_controller.sv
// Four-player quiz buzzer: arbitrates the first key press after the host
// starts a round, runs the answer countdown and flags early presses.
module quiz_race_controller
  import quiz_pkg::*;
#(
  parameter int               T1S    = 50_000_000,
  parameter logic [BCD_W-1:0] INIT_H = 4'd3,
  parameter logic [BCD_W-1:0] INIT_L = 4'd0,
  parameter int               T_BUZZ = 25_000_000
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Host_Start,
  input  logic             Host_Clear,
  input  logic [3:0]       Player_Key,
  output logic [3:0]       Player_Number,
  output logic [BCD_W-1:0] TimerH,
  output logic [BCD_W-1:0] TimerL,
  output logic             Buzzer,
  output logic             Foul_Flag
);
  localparam int PW = (T1S > 1) ? $clog2(T1S) : 1;
  localparam int BW = $clog2(T_BUZZ + 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    player_q, player_d;
  logic          start_prev_q, buzz_q, buzz_d, foul_q, foul_d;
  logic          key_any, start_rise, sec_tick, dec, load, zero_next, entry;

  assign key_any    = |Player_Key;
  assign start_rise = Host_Start & ~start_prev_q;
  assign sec_tick   = (state_q == ST_ARMED) && (pre_q == PW'(T1S - 1));

  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    if (Host_Clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_any)         state_d = ST_FOUL;
          else if (start_rise) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          // A key in the same cycle as the final tick wins: value stays at 01.
          if (key_any) begin
            state_d = ST_LOCKED;
          end else if (sec_tick) begin
            dec = 1'b1;
            if (zero_next) state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pre_d = '0;
    if (state_q == ST_ARMED && state_d == ST_ARMED && !sec_tick)
      pre_d = pre_q + 1'b1;

    case (state_d)
      ST_IDLE:             player_d = PLAYER_BLANK;
      ST_LOCKED, ST_FOUL:  player_d = (state_q != state_d) ? prio_player(Player_Key) : player_q;
      default:             player_d = PLAYER_NONE;
    endcase

    entry = (state_d != state_q) &&
            (state_d == ST_LOCKED || state_d == ST_TIMEOUT || state_d == ST_FOUL);
    buzz_d = buzz_q;
    bcnt_d = bcnt_q;
    if (state_d == ST_IDLE) begin
      buzz_d = 1'b0;
      bcnt_d = '0;
    end else if (entry) begin
      buzz_d = 1'b1;
      bcnt_d = BW'(T_BUZZ - 1);
    end else if (buzz_q) begin
      if (bcnt_q == '0) buzz_d = 1'b0;
      else              bcnt_d = bcnt_q - 1'b1;
    end

    foul_d = (state_d == ST_FOUL);
  end

  // Keep the preset loaded while idle so the display shows it and ARMED starts fresh.
  assign load = (state_d == ST_IDLE) || (state_q == ST_IDLE);

  bcd_down_counter2 #(.INIT_H(INIT_H), .INIT_L(INIT_L)) u_cnt (
    .clk       (CLK),
    .rst_n     (RSTn),
    .load      (load),
    .dec       (dec),
    .dig_h     (TimerH),
    .dig_l     (TimerL),
    .zero_next (zero_next)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      bcnt_q       <= '0;
      player_q     <= PLAYER_BLANK;
      start_prev_q <= 1'b0;
      buzz_q       <= 1'b0;
      foul_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      bcnt_q       <= bcnt_d;
      player_q     <= player_d;
      start_prev_q <= Host_Start;
      buzz_q       <= buzz_d;
      foul_q       <= foul_d;
    end
  end

  assign Player_Number = player_q;
  assign Buzzer        = buzz_q;
  assign Foul_Flag     = foul_q;
endmodule

// File: tb/tb_quiz_race_controller.sv
// Directed bench for quiz_race_controller: preset 03 instance for most
// scenarios, preset 10 instance for the borrow / final-tick race.
module tb_quiz_race_controller;
  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Host_Start = 1'b0;
  logic       Host_Clear = 1'b0;
  logic [3:0] Player_Key = 4'b0;
  logic [3:0] pn, th, tl, b_pn, b_th, b_tl;
  logic       bz, ff, b_bz, b_ff;
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  quiz_race_controller #(.T1S(10), .INIT_H(4'd0), .INIT_L(4'd3), .T_BUZZ(5)) dut (
    .CLK(CLK), .RSTn(RSTn), .Host_Start(Host_Start), .Host_Clear(Host_Clear),
    .Player_Key(Player_Key), .Player_Number(pn), .TimerH(th), .TimerL(tl),
    .Buzzer(bz), .Foul_Flag(ff));

  quiz_race_controller #(.T1S(10), .INIT_H(4'd1), .INIT_L(4'd0), .T_BUZZ(5)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .Host_Start(Host_Start), .Host_Clear(Host_Clear),
    .Player_Key(Player_Key), .Player_Number(b_pn), .TimerH(b_th), .TimerL(b_tl),
    .Buzzer(b_bz), .Foul_Flag(b_ff));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm();
    Host_Start = 1'b1;
    tick();
    Host_Start = 1'b0;
  endtask

  task automatic clear();
    Host_Clear = 1'b1;
    tick();
    Host_Clear = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    #12;
    checks++;
    if ({pn, th, tl, bz, ff} !== {4'd10, 4'd0, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: pn=%0d t=%0d%0d bz=%b ff=%b, want 10 03 0 0", pn, th, tl, bz, ff);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    Host_Start = 1'b1;
    tick();
    checks++;
    if (pn !== 4'd0) begin errors++; $display("FAIL armed_pn: got %0d want 0", pn); end
    repeat (14) tick();
    Player_Key = 4'b0100;
    tick();
    Player_Key = 4'b0;
    checks++;
    if ({pn, th, tl, bz} !== {4'd3, 4'd0, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL lock_p3: pn=%0d t=%0d%0d bz=%b, want 3 02 1", pn, th, tl, bz);
    end
    repeat (4) tick();
    checks++;
    if (bz !== 1'b1) begin errors++; $display("FAIL lock_buzz_5th: got %b want 1", bz); end
    tick();
    checks++;
    if ({bz, th, tl} !== {1'b0, 4'd0, 4'd2}) begin
      errors++;
      $display("FAIL lock_buzz_end_frozen: bz=%b t=%0d%0d, want 0 02", bz, th, tl);
    end
    clear();
    tick();
    checks++;
    if (pn !== 4'd10) begin errors++; $display("FAIL held_start_no_retrig: got %0d want 10", pn); end
    Host_Start = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    arm();
    repeat (9) tick();
    checks++;
    if ({th, tl} !== {4'd0, 4'd3}) begin errors++; $display("FAIL to_t9: got %0d%0d want 03", th, tl); end
    tick();
    checks++;
    if ({th, tl} !== {4'd0, 4'd2}) begin errors++; $display("FAIL to_t10: got %0d%0d want 02", th, tl); end
    repeat (10) tick();
    checks++;
    if ({th, tl} !== {4'd0, 4'd1}) begin errors++; $display("FAIL to_t20: got %0d%0d want 01", th, tl); end
    repeat (9) tick();
    checks++;
    if ({th, tl, bz} !== {4'd0, 4'd1, 1'b0}) begin
      errors++; $display("FAIL to_t29: t=%0d%0d bz=%b want 01 0", th, tl, bz);
    end
    tick();
    checks++;
    if ({pn, th, tl, bz} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL to_t30: pn=%0d t=%0d%0d bz=%b want 0 00 1", pn, th, tl, bz);
    end
    Player_Key = 4'b0001;
    tick();
    Player_Key = 4'b0;
    checks++;
    if (pn !== 4'd0) begin errors++; $display("FAIL to_key_ignored: got %0d want 0", pn); end
    repeat (3) tick();
    checks++;
    if (bz !== 1'b1) begin errors++; $display("FAIL to_buzz_5th: got %b want 1", bz); end
    tick();
    checks++;
    if (bz !== 1'b0) begin errors++; $display("FAIL to_buzz_end: got %b want 0", bz); end
    clear();
  endtask

  task automatic test_foul();
    Player_Key = 4'b1000;
    tick();
    Player_Key = 4'b0;
    checks++;
    if ({pn, ff, bz} !== {4'd4, 1'b1, 1'b1}) begin
      errors++; $display("FAIL foul_p4: pn=%0d ff=%b bz=%b want 4 1 1", pn, ff, bz);
    end
    arm();
    tick();
    checks++;
    if ({pn, ff} !== {4'd4, 1'b1}) begin
      errors++; $display("FAIL foul_start_ignored: pn=%0d ff=%b want 4 1", pn, ff);
    end
    clear();
    checks++;
    if ({pn, ff, bz} !== {4'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL foul_clear: pn=%0d ff=%b bz=%b want 10 0 0", pn, ff, bz);
    end
    tick();
    Host_Start = 1'b1;
    Player_Key = 4'b0110;
    tick();
    Host_Start = 1'b0;
    Player_Key = 4'b0;
    checks++;
    if ({pn, ff} !== {4'd2, 1'b1}) begin
      errors++; $display("FAIL foul_vs_start: pn=%0d ff=%b want 2 1", pn, ff);
    end
    clear();
  endtask

  task automatic test_priority();
    arm();
    tick();
    Player_Key = 4'b1010;
    tick();
    checks++;
    if (pn !== 4'd2) begin errors++; $display("FAIL prio_1010: got %0d want 2", pn); end
    Player_Key = 4'b0001;
    tick();
    Player_Key = 4'b0;
    checks++;
    if ({pn, ff} !== {4'd2, 1'b0}) begin
      errors++; $display("FAIL locked_hold: pn=%0d ff=%b want 2 0", pn, ff);
    end
    clear();
  endtask

  task automatic test_clear_reset();
    arm();
    repeat (3) tick();
    Host_Clear = 1'b1;
    Player_Key = 4'b0001;
    tick();
    Host_Clear = 1'b0;
    Player_Key = 4'b0;
    checks++;
    if ({pn, bz, th, tl} !== {4'd10, 1'b0, 4'd0, 4'd3}) begin
      errors++; $display("FAIL clear_wins: pn=%0d bz=%b t=%0d%0d want 10 0 03", pn, bz, th, tl);
    end
    tick();
    arm();
    repeat (12) tick();
    Player_Key = 4'b0100;
    tick();
    Player_Key = 4'b0;
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if ({pn, th, tl, bz, ff} !== {4'd10, 4'd0, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: pn=%0d t=%0d%0d bz=%b ff=%b want 10 03 0 0", pn, th, tl, bz, ff);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_borrow();
    arm();
    repeat (10) tick();
    checks++;
    if ({b_th, b_tl} !== {4'd0, 4'd9}) begin
      errors++; $display("FAIL borrow_09: got %0d%0d want 09", b_th, b_tl);
    end
    repeat (80) tick();
    checks++;
    if ({b_th, b_tl} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL borrow_01: got %0d%0d want 01", b_th, b_tl);
    end
    repeat (9) tick();
    Player_Key = 4'b0010;
    tick();
    Player_Key = 4'b0;
    checks++;
    if ({b_pn, b_th, b_tl, b_bz} !== {4'd2, 4'd0, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL final_tick_race: pn=%0d t=%0d%0d bz=%b want 2 01 1", b_pn, b_th, b_tl, b_bz);
    end
    clear();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_foul();
    test_priority();
    test_clear_reset();
    test_borrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
